layer_relu_collector: RTL and testbench
=======================================

// Module: layer_relu_collector
// PURPOSE
// - Downstream of the per-node feed-forward stage in the target net: gathers the NUMBER_OF_NODE
//   fp32 node sums of one layer, applies ReLU, and buffers them.
// - Once every node has reported, streams the activations in node order (addr 0..N-1) with a
//   valid/ready handshake into the next layer's input path.
// PARAMETERS
// - DATA_WIDTH      32  IEEE-754 single word width. Sign bit is DATA_WIDTH-1.
// - ADDRESS_WIDTH   5   Width of o_addr. Requires 2**ADDRESS_WIDTH >= NUMBER_OF_NODE.
// - NUMBER_OF_NODE  32  Nodes in the layer. Legal range is 2..2**ADDRESS_WIDTH.
// PORTS
// - clk      in   1                            Single clock, rising edge.
// - rst      in   1                            Synchronous, active-high reset.
// - i_start  in   1                            Opens a new layer pass: clears buffer and mask.
// - i_valid  in   NUMBER_OF_NODE               Per-node result strobe; bit k qualifies slice k.
// - i_data   in   NUMBER_OF_NODE*DATA_WIDTH    Node k sum is at [k*DATA_WIDTH +: DATA_WIDTH].
// - o_data   out  DATA_WIDTH                   ReLU activation for node o_addr.
// - o_addr   out  ADDRESS_WIDTH                Node index of o_data.
// - o_valid  out  1                            o_data and o_addr are valid.
// - i_ready  in   1                            Consumer accepts when o_valid && i_ready.
// - o_last   out  1                            High with o_valid when o_addr == NUMBER_OF_NODE-1.
// - o_done   out  1                            One-cycle pulse after the last beat is accepted.
// BEHAVIOUR
// - Reset: state IDLE; o_valid=0, o_last=0, o_done=0, o_addr=0, o_data=0; mask and buffer cleared.
// - ReLU: if the sign bit is 1, store 32'h0000_0000. This covers -0.0 and negative NaN. Otherwise
//   store the word unchanged, including +NaN and +Inf. No other fp arithmetic is performed.
// - FSM IDLE: i_valid is ignored. On i_start, clear mask and buffer and go to COLLECT next cycle.
// - FSM COLLECT: for each k with i_valid[k]=1 and mask[k]=0, register relu(slice k) into buf[k]
//   and set mask[k]. Several k may be captured in the same cycle.
// - Duplicate strobe: if mask[k]=1, the repeat is dropped and the first value is kept.
// - COLLECT to STREAM: in the cycle after the mask becomes all-ones, go to STREAM with o_addr=0
//   and o_valid=1. Latency from the last capturing edge to the first o_valid is 1 cycle.
// - FSM STREAM: o_data=buf[o_addr] and o_valid=1. On o_valid && i_ready, o_addr increments.
// - Backpressure: while i_ready=0, o_data and o_addr hold stable.
// - Stream end: when the beat at addr N-1 is accepted, go to IDLE. In that cycle o_valid=0 and
//   o_done=1, and o_addr returns to 0.
// - i_valid is ignored in STREAM.
// - i_start in COLLECT or STREAM aborts the pass. It clears mask and buffer, drops o_valid, does
//   not pulse o_done, and re-enters COLLECT next cycle.
// - i_start together with i_valid in the same cycle: the clear wins and that cycle's strobes are lost.
// - i_start in the o_done cycle (IDLE) is legal and starts a new pass.
// - rst overrides everything in any state. The next pass needs a fresh i_start.
// STRUCTURE
// - Shared package dqn_pkg holds:
//   - typedef collector_state_t {IDLE, COLLECT, STREAM}
//   - localparam FP_ZERO = 32'h0000_0000
// - Sub-module fp_relu: combinational, DATA_WIDTH in and DATA_WIDTH out. One instance per node lane.
// - Top level holds the FSM, the NUMBER_OF_NODE-bit mask, the buffer register array, and the
//   o_addr counter. The o_data read mux is indexed by o_addr.
// TESTING
// All scenarios use NUMBER_OF_NODE=4 and i_ready=1 unless stated otherwise.
// 1. Capture and stream, with reset at end:
//    - start; strobe node0=3F80_0000, node1=BF80_0000, node2=8000_0000, node3=4000_0000 on
//      separate cycles.
//    - Stream must be (0,3F800000), (1,0), (2,0), (3,40000000). o_last is high on addr 3, and o_done
//      pulses 1 cycle after that beat.
//    - After the stream, assert rst for 1 cycle; all outputs must read 0.
// 2. Simultaneous strobes:
//    - i_valid=4'b1111 in one cycle with values 1.0, 2.0, -3.0, 0.5.
//    - o_valid must rise exactly 1 cycle later. Stream must be 3F800000, 40000000, 0, 3F000000.
// 3. Duplicate strobe:
//    - node2=4040_0000, then node2 again with 4080_0000 before nodes 0, 1, 3 report.
//    - Streamed addr2 must be 40400000.
// 4. Backpressure: i_ready=0 for 3 cycles on the addr1 beat.
//    - o_addr=1 and o_data must stay stable for those cycles.
//    - Exactly 4 beats total, and o_done fires once.
// 5. Abort: i_start mid-COLLECT after 2 nodes, then all 4 nodes report new values.
//    - Only the new values appear in the stream, and no o_done occurs before the new stream ends.
// 6. Reset mid-stream: rst during the addr2 beat.
//    - Next cycle all outputs are 0 and state is IDLE.
//    - Strobes without i_start produce no output.

Source files
------------

// File: rtl/dqn_pkg.sv
// Shared types and constants for the feed-forward datapath blocks.
package dqn_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    STREAM  = 2'd2
  } collector_state_t;

  localparam logic [31:0] FP_ZERO = 32'h0000_0000;

endpackage

// File: rtl/fp_relu.sv
// Combinational fp ReLU: any word with the sign bit set (incl. -0.0, -NaN) becomes +0.0.
module fp_relu
  import dqn_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  assign dout = din[DATA_WIDTH-1] ? DATA_WIDTH'(FP_ZERO) : din;

endmodule

// File: rtl/layer_relu_collector.sv
// Gathers one layer's node sums through ReLU, then streams them out in node order.
module layer_relu_collector
  import dqn_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDRESS_WIDTH  = 5,
  parameter int NUMBER_OF_NODE = 32
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 i_start,
  input  logic [NUMBER_OF_NODE-1:0]            i_valid,
  input  logic [NUMBER_OF_NODE*DATA_WIDTH-1:0] i_data,
  output logic [DATA_WIDTH-1:0]                o_data,
  output logic [ADDRESS_WIDTH-1:0]             o_addr,
  output logic                                 o_valid,
  input  logic                                 i_ready,
  output logic                                 o_last,
  output logic                                 o_done
);

  localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = ADDRESS_WIDTH'(NUMBER_OF_NODE - 1);

  collector_state_t                                state_q;
  logic [NUMBER_OF_NODE-1:0]                       mask_q;
  logic [NUMBER_OF_NODE-1:0][DATA_WIDTH-1:0]       relu_d;
  logic [NUMBER_OF_NODE-1:0][DATA_WIDTH-1:0]       buf_q;

  for (genvar k = 0; k < NUMBER_OF_NODE; k++) begin : g_lane
    fp_relu #(.DATA_WIDTH(DATA_WIDTH)) u_relu (
      .din  (i_data[k*DATA_WIDTH +: DATA_WIDTH]),
      .dout (relu_d[k])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mask_q  <= '0;
      buf_q   <= '0;
      o_addr  <= '0;
      o_valid <= 1'b0;
      o_done  <= 1'b0;
    end else begin
      o_done <= 1'b0;
      // Start (or abort) takes priority over any strobes in the same cycle.
      if (i_start) begin
        state_q <= COLLECT;
        mask_q  <= '0;
        buf_q   <= '0;
        o_addr  <= '0;
        o_valid <= 1'b0;
      end else begin
        unique case (state_q)
          IDLE: ;
          COLLECT: begin
            for (int k = 0; k < NUMBER_OF_NODE; k++) begin
              if (i_valid[k] && !mask_q[k]) begin
                buf_q[k]  <= relu_d[k];
                mask_q[k] <= 1'b1;
              end
            end
            // Registered mask check gives one cycle from the final capture to o_valid.
            if (&mask_q) begin
              state_q <= STREAM;
              o_addr  <= '0;
              o_valid <= 1'b1;
            end
          end
          STREAM: begin
            if (i_ready) begin
              if (o_addr == LAST_ADDR) begin
                state_q <= IDLE;
                o_addr  <= '0;
                o_valid <= 1'b0;
                o_done  <= 1'b1;
              end else begin
                o_addr <= o_addr + ADDRESS_WIDTH'(1);
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign o_data = o_valid ? buf_q[o_addr] : '0;
  assign o_last = o_valid && (o_addr == LAST_ADDR);

endmodule

// File: tb/tb_layer_relu_collector.sv
// Directed + randomized bench for layer_relu_collector (4 nodes) against a spec-level model.
module tb_layer_relu_collector;

  localparam int DW = 32;
  localparam int AW = 2;
  localparam int NN = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_start;
  logic [NN-1:0]     i_valid;
  logic [NN*DW-1:0]  i_data;
  logic [DW-1:0]     o_data;
  logic [AW-1:0]     o_addr;
  logic              o_valid;
  logic              i_ready;
  logic              o_last;
  logic              o_done;

  int checks = 0;
  int errors = 0;

  // Reference model: what each node's activation should be, and who has reported.
  logic [31:0] model_buf [NN];
  logic [NN-1:0] got;
  bit collecting;

  layer_relu_collector #(
    .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .NUMBER_OF_NODE(NN)
  ) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_valid(i_valid), .i_data(i_data),
    .o_data(o_data), .o_addr(o_addr), .o_valid(o_valid), .i_ready(i_ready),
    .o_last(o_last), .o_done(o_done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] relu(input logic [31:0] v);
    return (v[31] == 1'b1) ? 32'h0 : v;
  endfunction

  function automatic logic [31:0] rand_word();
    case ($urandom % 7)
      0: return 32'h8000_0000;
      1: return 32'hFFC0_0000;
      2: return 32'h7FC0_0000;
      3: return 32'h7F80_0000;
      default: return $urandom;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic chk_zero_outs(input string tag);
    chk({tag, "_valid"}, 32'(o_valid), 32'h0);
    chk({tag, "_last"},  32'(o_last),  32'h0);
    chk({tag, "_done"},  32'(o_done),  32'h0);
    chk({tag, "_addr"},  32'(o_addr),  32'h0);
    chk({tag, "_data"},  o_data,       32'h0);
  endtask

  task automatic model_clear();
    got = '0;
    foreach (model_buf[k]) model_buf[k] = 32'h0;
  endtask

  // Present one cycle of inputs; returns at the negedge after the capturing edge.
  task automatic strobe(input logic [NN-1:0] v, input logic [NN-1:0][31:0] d, input bit st);
    i_valid = v;
    i_data  = d;
    i_start = st;
    if (st) begin
      model_clear();
      collecting = 1'b1;
    end else if (collecting) begin
      for (int k = 0; k < NN; k++)
        if (v[k] && !got[k]) begin
          model_buf[k] = relu(d[k]);
          got[k] = 1'b1;
        end
    end
    @(negedge clk);
    i_valid = '0;
    i_start = 1'b0;
  endtask

  task automatic do_start();
    strobe('0, '0, 1'b1);
  endtask

  task automatic do_rst();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    collecting = 1'b0;
    model_clear();
  endtask

  // mode 0: always ready, 1: random ready, 2: stall 3 cycles at beat stall_at.
  task automatic run_stream(input int mode, input int stall_at, input int rst_at);
    int beat;
    int stalls;
    bit rdy;
    bit fin;
    beat = 0; stalls = 0; fin = 1'b0;
    @(negedge clk);
    chk("first_valid", 32'(o_valid), 32'h1);
    for (int cyc = 0; cyc < 80 && !fin; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (beat == NN) begin
        chk("done_pulse", 32'(o_done),  32'h1);
        chk("end_valid",  32'(o_valid), 32'h0);
        chk("end_addr",   32'(o_addr),  32'h0);
        chk("end_last",   32'(o_last),  32'h0);
        fin = 1'b1;
      end else begin
        chk("beat_valid", 32'(o_valid), 32'h1);
        chk("early_done", 32'(o_done),  32'h0);
        chk("beat_addr",  32'(o_addr),  32'(beat));
        chk("beat_data",  o_data,       model_buf[beat]);
        chk("beat_last",  32'(o_last),  32'(beat == NN - 1));
        if (beat == rst_at) begin
          do_rst();
          chk_zero_outs("rst_mid");
          fin = 1'b1;
        end else begin
          case (mode)
            1: rdy = ($urandom % 3) != 0;
            2: rdy = !(beat == stall_at && stalls < 3);
            default: rdy = 1'b1;
          endcase
          if (!rdy) stalls++;
          i_ready = rdy;
          if (rdy) beat++;
        end
      end
    end
    i_ready = 1'b1;
    collecting = 1'b0;
    if (!fin) begin
      checks++;
      errors++;
      $error("FAIL stream_timeout: got %0d beats expected %0d", beat, NN);
    end
  endtask

  initial begin
    logic [NN-1:0][31:0] d;
    logic [NN-1:0] v;
    rst = 1'b1; i_start = 1'b0; i_valid = '0; i_data = '0; i_ready = 1'b1;
    collecting = 1'b0;
    model_clear();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk_zero_outs("reset");

    // 1: separate strobes, then reset after the stream
    do_start();
    d = '0;
    d[0] = 32'h3F80_0000; strobe(4'b0001, d, 1'b0);
    d[1] = 32'hBF80_0000; strobe(4'b0010, d, 1'b0);
    d[2] = 32'h8000_0000; strobe(4'b0100, d, 1'b0);
    chk("s1_pre_valid", 32'(o_valid), 32'h0);
    d[3] = 32'h4000_0000; strobe(4'b1000, d, 1'b0);
    chk("s1_latency", 32'(o_valid), 32'h0);
    run_stream(0, -1, -1);
    do_rst();
    chk_zero_outs("s1_rst");

    // 2: simultaneous strobes
    do_start();
    d[0] = 32'h3F80_0000; d[1] = 32'h4000_0000; d[2] = 32'hC040_0000; d[3] = 32'h3F00_0000;
    strobe(4'b1111, d, 1'b0);
    chk("s2_latency", 32'(o_valid), 32'h0);
    run_stream(0, -1, -1);

    // 3: duplicate strobe keeps the first value
    do_start();
    d = '0;
    d[2] = 32'h4040_0000; strobe(4'b0100, d, 1'b0);
    d[2] = 32'h4080_0000; strobe(4'b0100, d, 1'b0);
    chk("s3_model_n2", model_buf[2], 32'h4040_0000);
    for (int k = 0; k < NN; k++) d[k] = rand_word();
    strobe(4'b1011, d, 1'b0);
    run_stream(0, -1, -1);

    // 4: backpressure on addr1
    do_start();
    for (int k = 0; k < NN; k++) d[k] = rand_word();
    strobe(4'b1111, d, 1'b0);
    run_stream(2, 1, -1);
    @(negedge clk);
    chk("s4_done_once", 32'(o_done),  32'h0);
    chk("s4_idle",      32'(o_valid), 32'h0);

    // 5: abort mid-collect
    do_start();
    for (int k = 0; k < NN; k++) d[k] = rand_word();
    strobe(4'b0011, d, 1'b0);
    do_start();
    chk("s5_abort_done", 32'(o_done), 32'h0);
    for (int k = 0; k < NN; k++) d[k] = rand_word();
    strobe(4'b1111, d, 1'b0);
    run_stream(0, -1, -1);

    // 6: reset during addr2 beat, then strobes without start are ignored
    do_start();
    for (int k = 0; k < NN; k++) d[k] = rand_word();
    strobe(4'b1111, d, 1'b0);
    run_stream(0, -1, 2);
    strobe(4'b1111, d, 1'b0);
    for (int c = 0; c < 3; c++) begin
      chk("s6_no_out", 32'(o_valid), 32'h0);
      @(negedge clk);
    end

    // Random passes: start/strobe collisions, duplicates, random backpressure
    for (int pass = 0; pass < 8; pass++) begin
      do_start();
      if (pass % 2 == 1) begin
        for (int k = 0; k < NN; k++) d[k] = rand_word();
        strobe(4'($urandom), d, 1'b1);
      end
      for (int n = 0; n < 100 && got != '1; n++) begin
        for (int k = 0; k < NN; k++) d[k] = rand_word();
        v = 4'($urandom);
        if (got != '1) chk("rnd_pre_valid", 32'(o_valid), 32'h0);
        strobe(v, d, 1'b0);
      end
      run_stream(1, -1, -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
